// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-order branch resolution, predictor update, flush/redirect and stats
// Tracks in-flight branch predictions in a small FIFO and resolves them oldest-first.
module branch_resolver #(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2,
  parameter int IDX_BITS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                F_Branch,
  input  logic                F_Prediction,
  input  logic [31:0]         F_PC,
  output logic                Stall,
  input  logic                E_Resolve,
  input  logic                E_Taken,
  input  logic [31:0]         E_Target,
  output logic                Upd_Valid,
  output logic [1:0]          pred_actual,
  output logic [IDX_BITS-1:0] Upd_Index,
  output logic                Flush,
  output logic [31:0]         Redirect_PC,
  output logic [15:0]         Branch_Count,
  output logic [15:0]         Mispred_Count,
  output logic                Err
);

  logic                r_pred [DEPTH];
  logic [IDX_BITS-1:0] r_idx  [DEPTH];
  logic [31:0]         r_ft   [DEPTH];

  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [PTR_BITS:0]   r_count;

  logic                r_upd_valid;
  logic [1:0]          r_pred_actual;
  logic [IDX_BITS-1:0] r_upd_index;
  logic                r_flush;
  logic [31:0]         r_redirect_pc;
  logic [15:0]         r_branch_count;
  logic [15:0]         r_mispred_count;
  logic                r_err;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_head_pred;
  logic w_mispred;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (PTR_BITS+1)'(DEPTH));
  assign w_pop       = E_Resolve & ~w_empty;
  assign Stall       = F_Branch & w_full & ~w_pop;
  assign w_push      = F_Branch & ~Stall;
  assign w_head_pred = r_pred[r_rd_ptr];
  assign w_mispred   = w_pop & (w_head_pred != E_Taken);

  // Entry storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge Clock) begin
    if (w_push && !w_mispred) begin
      r_pred[r_wr_ptr] <= F_Prediction;
      r_idx[r_wr_ptr]  <= F_PC[IDX_BITS-1:0];
      r_ft[r_wr_ptr]   <= F_PC + 32'd4;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_upd_valid     <= 1'b0;
      r_pred_actual   <= 2'b00;
      r_upd_index     <= '0;
      r_flush         <= 1'b0;
      r_redirect_pc   <= 32'd0;
      r_branch_count  <= 16'd0;
      r_mispred_count <= 16'd0;
      r_err           <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      r_flush     <= w_mispred;
      if (E_Resolve && w_empty)
        r_err <= 1'b1;

      if (w_pop) begin
        r_pred_actual <= {w_head_pred, E_Taken};
        r_upd_index   <= r_idx[r_rd_ptr];
        if (r_branch_count != 16'hFFFF)
          r_branch_count <= r_branch_count + 16'd1;
      end

      // A mispredict squashes every younger entry, including one arriving this cycle.
      if (w_mispred) begin
        r_redirect_pc <= E_Taken ? E_Target : r_ft[r_rd_ptr];
        if (r_mispred_count != 16'hFFFF)
          r_mispred_count <= r_mispred_count + 16'd1;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
        if (w_push && !w_pop)
          r_count <= r_count + (PTR_BITS+1)'(1);
        else if (w_pop && !w_push)
          r_count <= r_count - (PTR_BITS+1)'(1);
      end
    end
  end

  assign Upd_Valid     = r_upd_valid;
  assign pred_actual   = r_pred_actual;
  assign Upd_Index     = r_upd_index;
  assign Flush         = r_flush;
  assign Redirect_PC   = r_redirect_pc;
  assign Branch_Count  = r_branch_count;
  assign Mispred_Count = r_mispred_count;
  assign Err           = r_err;

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - self-checking bench for branch_resolver
// Directed vector table, queue-based reference model with random traffic, and corner sequences.
module tb_branch_resolver;

  localparam int DEPTH = 4;

  logic        Clock;
  logic        Reset;
  logic        F_Branch;
  logic        F_Prediction;
  logic [31:0] F_PC;
  logic        Stall;
  logic        E_Resolve;
  logic        E_Taken;
  logic [31:0] E_Target;
  logic        Upd_Valid;
  logic [1:0]  pred_actual;
  logic [3:0]  Upd_Index;
  logic        Flush;
  logic [31:0] Redirect_PC;
  logic [15:0] Branch_Count;
  logic [15:0] Mispred_Count;
  logic        Err;

  branch_resolver #(.DEPTH(4), .PTR_BITS(2), .IDX_BITS(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .F_Branch(F_Branch), .F_Prediction(F_Prediction), .F_PC(F_PC),
    .Stall(Stall),
    .E_Resolve(E_Resolve), .E_Taken(E_Taken), .E_Target(E_Target),
    .Upd_Valid(Upd_Valid), .pred_actual(pred_actual), .Upd_Index(Upd_Index),
    .Flush(Flush), .Redirect_PC(Redirect_PC),
    .Branch_Count(Branch_Count), .Mispred_Count(Mispred_Count), .Err(Err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of in-flight branches plus plain counters.
  typedef struct {
    logic       pred;
    logic [3:0] idx;
    logic [31:0] ft;
  } ent_t;

  ent_t        q[$];
  int          m_bc, m_mc;
  logic [31:0] m_rpc;
  logic        m_err;

  task automatic model_reset();
    q.delete();
    m_bc = 0; m_mc = 0; m_rpc = 32'd0; m_err = 1'b0;
  endtask

  task automatic step(input logic fb, input logic fpr, input logic [31:0] fpc,
                      input logic er, input logic et, input logic [31:0] tgt,
                      output logic stall_seen);
    logic exp_stall, pop, mis, m_valid, m_flush;
    logic [1:0] m_pa;
    logic [3:0] m_idx;
    ent_t h, e;
    F_Branch = fb; F_Prediction = fpr; F_PC = fpc;
    E_Resolve = er; E_Taken = et; E_Target = tgt;
    #1;
    pop = er && (q.size() != 0);
    exp_stall = fb && (q.size() == DEPTH) && !pop;
    stall_seen = Stall;
    chk("stall", {31'd0, Stall}, {31'd0, exp_stall});
    mis = 1'b0; m_valid = 1'b0; m_flush = 1'b0; m_pa = 2'b00; m_idx = 4'h0;
    if (pop) begin
      h = q.pop_front();
      m_valid = 1'b1;
      m_pa = {h.pred, et};
      m_idx = h.idx;
      if (m_bc < 65535) m_bc++;
      if (h.pred != et) begin
        mis = 1'b1;
        m_flush = 1'b1;
        if (m_mc < 65535) m_mc++;
        m_rpc = et ? tgt : h.ft;
        q.delete();
      end
    end else if (er) begin
      m_err = 1'b1;
    end
    if (fb && !exp_stall && !mis) begin
      e.pred = fpr; e.idx = fpc[3:0]; e.ft = fpc + 32'd4;
      q.push_back(e);
    end
    @(posedge Clock);
    #1;
    chk("upd_valid", {31'd0, Upd_Valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("pred_actual", {30'd0, pred_actual}, {30'd0, m_pa});
      chk("upd_index", {28'd0, Upd_Index}, {28'd0, m_idx});
    end
    chk("flush", {31'd0, Flush}, {31'd0, m_flush});
    chk("redirect_pc", Redirect_PC, m_rpc);
    chk("branch_count", {16'd0, Branch_Count}, m_bc);
    chk("mispred_count", {16'd0, Mispred_Count}, m_mc);
    chk("err", {31'd0, Err}, {31'd0, m_err});
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    F_Branch = 1'b0; E_Resolve = 1'b0;
    #1;
    Reset = 1'b1;
    model_reset();
  endtask

  // Directed vector table: inputs for one cycle and outputs expected after its edge.
  typedef struct {
    logic        fb, pred;
    logic [31:0] pc;
    logic        er, et;
    logic [31:0] tgt;
    logic        x_stall, x_valid;
    logic [1:0]  x_pa;
    logic [3:0]  x_idx;
    logic        x_flush;
    logic [31:0] x_rpc;
    logic [15:0] x_bc, x_mc;
  } vec_t;

  function automatic vec_t mk(logic fb, logic pred, logic [31:0] pc, logic er, logic et,
                              logic [31:0] tgt, logic xv, logic [1:0] xpa, logic [3:0] xi,
                              logic xf, logic [31:0] xr, logic [15:0] xb, logic [15:0] xm);
    vec_t v;
    v.fb = fb; v.pred = pred; v.pc = pc; v.er = er; v.et = et; v.tgt = tgt;
    v.x_stall = 1'b0; v.x_valid = xv; v.x_pa = xpa; v.x_idx = xi;
    v.x_flush = xf; v.x_rpc = xr; v.x_bc = xb; v.x_mc = xm;
    return v;
  endfunction

  vec_t vecs[7];
  logic st;

  initial begin
    Reset = 1'b0;
    F_Branch = 1'b0; F_Prediction = 1'b0; F_PC = 32'd0;
    E_Resolve = 1'b0; E_Taken = 1'b0; E_Target = 32'd0;
    model_reset();

    vecs[0] = mk(1, 1, 32'h0000_0010, 0, 0, 32'h0,        0, 2'b00, 4'h0, 0, 32'h0,        16'd0, 16'd0);
    vecs[1] = mk(0, 0, 32'h0,         1, 1, 32'h0000_0300, 1, 2'b11, 4'h0, 0, 32'h0,        16'd1, 16'd0);
    vecs[2] = mk(1, 1, 32'h0000_0024, 0, 0, 32'h0,        0, 2'b00, 4'h0, 0, 32'h0,        16'd1, 16'd0);
    vecs[3] = mk(0, 0, 32'h0,         1, 0, 32'h0000_0200, 1, 2'b10, 4'h4, 1, 32'h0000_0028, 16'd2, 16'd1);
    vecs[4] = mk(1, 0, 32'h0000_0038, 0, 0, 32'h0,        0, 2'b00, 4'h0, 0, 32'h0000_0028, 16'd2, 16'd1);
    vecs[5] = mk(0, 0, 32'h0,         1, 1, 32'h0000_0100, 1, 2'b01, 4'h8, 1, 32'h0000_0100, 16'd3, 16'd2);
    vecs[6] = mk(0, 0, 32'h0,         0, 0, 32'h0,        0, 2'b00, 4'h0, 0, 32'h0000_0100, 16'd3, 16'd2);

    #2;
    chk("rst_upd_valid", {31'd0, Upd_Valid}, 32'd0);
    chk("rst_pred_actual", {30'd0, pred_actual}, 32'd0);
    chk("rst_flush", {31'd0, Flush}, 32'd0);
    chk("rst_redirect", Redirect_PC, 32'd0);
    chk("rst_counts", {Branch_Count, Mispred_Count}, 32'd0);
    chk("rst_err", {31'd0, Err}, 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      F_Branch = vecs[i].fb; F_Prediction = vecs[i].pred; F_PC = vecs[i].pc;
      E_Resolve = vecs[i].er; E_Taken = vecs[i].et; E_Target = vecs[i].tgt;
      #1;
      chk("vec_stall", {31'd0, Stall}, {31'd0, vecs[i].x_stall});
      @(posedge Clock); #1;
      chk("vec_upd_valid", {31'd0, Upd_Valid}, {31'd0, vecs[i].x_valid});
      if (vecs[i].x_valid) begin
        chk("vec_pred_actual", {30'd0, pred_actual}, {30'd0, vecs[i].x_pa});
        chk("vec_upd_index", {28'd0, Upd_Index}, {28'd0, vecs[i].x_idx});
      end
      chk("vec_flush", {31'd0, Flush}, {31'd0, vecs[i].x_flush});
      chk("vec_redirect", Redirect_PC, vecs[i].x_rpc);
      chk("vec_branch_count", {16'd0, Branch_Count}, {16'd0, vecs[i].x_bc});
      chk("vec_mispred_count", {16'd0, Mispred_Count}, {16'd0, vecs[i].x_mc});
      chk("vec_err", {31'd0, Err}, 32'd0);
    end

    // Full FIFO: push dropped without a pop, accepted alongside a correct pop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 32'h40 + 32'(i) * 4, 0, 0, 0, st);
    step(1, 1, 32'h50, 0, 0, 0, st);
    chk("full_stall", {31'd0, st}, 32'd1);
    step(1, 1, 32'h50, 1, 1, 32'h0, st);
    chk("full_pop_no_stall", {31'd0, st}, 32'd0);
    chk("full_pop_count", {16'd0, Branch_Count}, 32'd1);
    step(1, 1, 32'h54, 0, 0, 0, st);
    chk("still_full_stall", {31'd0, st}, 32'd1);

    // Mispredict with same-cycle push empties the FIFO; next resolve is an error.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, st);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h60 + 32'(i) * 4, 0, 0, 0, st);
    step(1, 1, 32'h70, 1, 0, 32'h0, st);
    chk("squash_flush", {31'd0, Flush}, 32'd1);
    chk("squash_redirect", Redirect_PC, 32'h64);
    step(0, 0, 0, 1, 1, 0, st);
    chk("empty_err", {31'd0, Err}, 32'd1);
    chk("empty_no_valid", {31'd0, Upd_Valid}, 32'd0);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 6, 1'($urandom), $urandom, $urandom_range(0, 1) == 1,
           1'($urandom), $urandom, st);

    // Counter saturation followed by an asynchronous reset mid-stream.
    do_reset();
    step(1, 1, 32'h80, 0, 0, 0, st);
    for (int i = 0; i < 65534; i++) step(1, 1, 32'h80, 1, 1, 0, st);
    chk("bc_preload", {16'd0, Branch_Count}, 32'h0000_FFFE);
    step(1, 1, 32'h80, 1, 1, 0, st);
    step(1, 1, 32'h80, 1, 1, 0, st);
    chk("bc_saturate", {16'd0, Branch_Count}, 32'h0000_FFFF);
    Reset = 1'b0;
    #1;
    chk("async_upd_valid", {31'd0, Upd_Valid}, 32'd0);
    chk("async_counts", {Branch_Count, Mispred_Count}, 32'd0);
    chk("async_flush_err", {30'd0, Flush, Err}, 32'd0);
    chk("async_redirect", Redirect_PC, 32'd0);
    #3;
    Reset = 1'b1;
    model_reset();
    step(0, 0, 0, 1, 1, 0, st);
    chk("discard_err", {31'd0, Err}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
